// File: rtl/usb_pkg.sv
// Shared USB 1.1 definitions: PID codes, receive FSM states and buffer sizing.
// Used by the rx packet controller, the data_buffer and the tx side.
package usb_pkg;

  localparam int         BUF_DEPTH = 64;
  localparam int         MAX_DATA  = 64;
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE
  } pid_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    TOKEN,
    HSHK,
    ERR
  } rx_state_t;

endpackage

// File: rtl/usb_rx_shifter.sv
// LSB-first byte assembler: byte_done_o and sr_o are combinational with the completing
// shift, so the caller sees the full byte in the same cycle. No backpressure.
module usb_rx_shifter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       shift_i,
  input  logic       d_bit_i,
  input  logic       clear_i,
  output logic [7:0] sr_o,
  output logic [2:0] bit_cnt_o,
  output logic       byte_done_o
);

  logic [6:0] sr_q;
  logic [2:0] cnt_q;
  logic [2:0] cnt_base;

  // clear restarts the count while still accepting a bit in the same cycle
  assign cnt_base    = clear_i ? 3'd0 : cnt_q;
  assign sr_o        = {d_bit_i, sr_q};
  assign bit_cnt_o   = cnt_q;
  assign byte_done_o = shift_i && (cnt_base == 3'd7);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= sr_o[7:1];
      cnt_q <= cnt_base + 3'd1;
    end else if (clear_i) begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// USB 1.1 rx packet controller: SYNC/PID decode, DATA payload to data_buffer with CRC16 stripped.
// Store strobe 1 cycle after the completing bit; a full buffer or oversize payload aborts the packet.
module usb_rx_packet_ctrl
  import usb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       shift_en_i,
  input  logic       d_bit_i,
  input  logic       eop_i,
  input  logic [6:0] buffer_occupancy_i,
  output logic       store_rx_packet_data_o,
  output logic [7:0] rx_packet_data_o,
  output logic       flush_o,
  output logic [3:0] rx_packet_o,
  output logic       rx_transfer_active_o,
  output logic       rx_data_ready_o,
  output logic       rx_error_o
);

  localparam logic [6:0] OCC_FULL = 7'(BUF_DEPTH);
  localparam logic [6:0] DATA_LIM = 7'(MAX_DATA);

  rx_state_t  state_q, state_d;
  logic [3:0] pkt_q, pkt_d;
  logic       active_q, active_d, ready_q, ready_d, error_q, error_d;
  logic       flush_q, flush_d, store_q, store_d;
  logic [7:0] data_q, data_d, h0_q, h0_d, h1_q, h1_d;
  logic [1:0] held_q, held_d;
  logic [6:0] cnt_q, cnt_d;

  logic       shift, byte_done;
  logic [7:0] rx_byte;
  logic [2:0] bit_cnt;

  // eop wins over a coincident bit
  assign shift = shift_en_i && !eop_i;

  usb_rx_shifter u_shifter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .shift_i    (shift),
    .d_bit_i    (d_bit_i),
    .clear_i    (state_q == IDLE),
    .sr_o       (rx_byte),
    .bit_cnt_o  (bit_cnt),
    .byte_done_o(byte_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pkt_q    <= '0;
      active_q <= 1'b0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      flush_q  <= 1'b0;
      store_q  <= 1'b0;
      data_q   <= '0;
      h0_q     <= '0;
      h1_q     <= '0;
      held_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      flush_q  <= flush_d;
      store_q  <= store_d;
      data_q   <= data_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    active_d = active_q;
    ready_d  = ready_q;
    error_d  = error_q;
    flush_d  = 1'b0;
    store_d  = 1'b0;
    data_d   = data_q;
    h0_d     = h0_q;
    h1_d     = h1_q;
    held_d   = held_q;
    cnt_d    = cnt_q;

    // an error detected at eop returns straight to IDLE: the packet is already over
    case (state_q)
      IDLE: begin
        if (shift) begin
          error_d = 1'b0;
          ready_d = 1'b0;
          pkt_d   = 4'h0;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (eop_i) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (byte_done) begin
          state_d = (rx_byte == SYNC_BYTE) ? PID : ERR;
        end
      end
      PID: begin
        if (eop_i) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (byte_done) begin
          if (rx_byte[3:0] != ~rx_byte[7:4]) begin
            state_d = ERR;
          end else begin
            pkt_d    = rx_byte[3:0];
            active_d = 1'b1;
            cnt_d    = '0;
            held_d   = '0;
            case (rx_byte[3:0])
              PID_DATA0, PID_DATA1: begin
                state_d = DATA;
                flush_d = 1'b1;
              end
              PID_OUT, PID_IN, PID_SETUP: state_d = TOKEN;
              PID_ACK, PID_NAK, PID_STALL: state_d = HSHK;
              default:                     state_d = ERR;
            endcase
          end
        end
      end
      TOKEN: begin
        if (eop_i) begin
          active_d = 1'b0;
          state_d  = IDLE;
          if (!(cnt_q == 7'd2 && bit_cnt == 3'd0)) error_d = 1'b1;
        end else if (byte_done && cnt_q != 7'd3) begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      HSHK: begin
        if (eop_i) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end else if (shift) begin
          state_d = ERR;
        end
      end
      DATA: begin
        if (eop_i) begin
          active_d = 1'b0;
          state_d  = IDLE;
          if (bit_cnt == 3'd0 && held_q == 2'd2) ready_d = 1'b1;
          else                                   error_d = 1'b1;
        end else if (byte_done) begin
          // the two most recent bytes stay held so the trailing CRC16 never reaches the buffer
          if (held_q == 2'd2) begin
            if (buffer_occupancy_i >= OCC_FULL || cnt_q >= DATA_LIM) begin
              state_d = ERR;
            end else begin
              store_d = 1'b1;
              data_d  = h1_q;
              cnt_d   = cnt_q + 7'd1;
              h1_d    = h0_q;
              h0_d    = rx_byte;
            end
          end else begin
            held_d = held_q + 2'd1;
            h1_d   = h0_q;
            h0_d   = rx_byte;
          end
        end
      end
      ERR: begin
        if (eop_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == ERR && state_q != ERR) begin
      error_d  = 1'b1;
      active_d = 1'b0;
    end
  end

  assign store_rx_packet_data_o = store_q;
  assign rx_packet_data_o       = data_q;
  assign flush_o                = flush_q;
  assign rx_packet_o            = pkt_q;
  assign rx_transfer_active_o   = active_q;
  assign rx_data_ready_o        = ready_q;
  assign rx_error_o             = error_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Randomized packet-level bench for usb_rx_packet_ctrl with a byte-list reference model.
module tb_usb_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shift_en = 1'b0;
  logic       d_bit = 1'b0;
  logic       eop = 1'b0;
  logic [6:0] occ = '0;
  logic       store;
  logic [7:0] sdat;
  logic       flush;
  logic [3:0] pkt;
  logic       active;
  logic       rdy;
  logic       err;

  usb_rx_packet_ctrl dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .shift_en_i            (shift_en),
    .d_bit_i               (d_bit),
    .eop_i                 (eop),
    .buffer_occupancy_i    (occ),
    .store_rx_packet_data_o(store),
    .rx_packet_data_o      (sdat),
    .flush_o               (flush),
    .rx_packet_o           (pkt),
    .rx_transfer_active_o  (active),
    .rx_data_ready_o       (rdy),
    .rx_error_o            (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] dat;
  } exp_t;

  exp_t       pend[$];
  int         flush_cyc = -1;
  logic [7:0] preset[$];
  logic       exp_st, exp_fl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // strobes and flush must appear exactly on the cycle the model predicts
  always @(negedge clk) begin
    if (!rst) begin
      exp_st = (pend.size() > 0) && (pend[0].cyc == cyc);
      if (store || exp_st) begin
        check_eq("store_vld", store, exp_st);
        if (exp_st) begin
          check_eq("store_dat", sdat, pend[0].dat);
          void'(pend.pop_front());
        end
      end
      exp_fl = (cyc == flush_cyc);
      if (flush || exp_fl) check_eq("flush", flush, exp_fl);
    end
  end

  task automatic drive_bit(input logic b);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      @(posedge clk); #1;
      shift_en = 1'b0;
      d_bit    = 1'($urandom);
    end
    @(posedge clk); #1;
    shift_en = 1'b1;
    d_bit    = b;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    shift_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_store"}, store, 0);
    check_eq({tag, "_sdat"}, sdat, 0);
    check_eq({tag, "_flush"}, flush, 0);
    check_eq({tag, "_pkt"}, pkt, 0);
    check_eq({tag, "_active"}, active, 0);
    check_eq({tag, "_rdy"}, rdy, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  // body = bytes after the PID (payload plus CRC for DATA); tail = stray bits before eop
  task automatic send_pkt(input logic [7:0] sync_b, input logic [7:0] pid_b, input int nbody,
                          input int tail, input int bias, input int abort_after);
    logic [7:0] body[$];
    bit         good, st_err;
    int         pty, nst;
    logic [3:0] exp_pkt;
    logic       exp_err;

    body = preset;
    preset.delete();
    while (body.size() < nbody) body.push_back(8'($urandom));
    good = (sync_b == 8'h80) && (pid_b[3:0] == ~pid_b[7:4]);
    case (pid_b[3:0])
      4'h3, 4'hB:       pty = 0;
      4'h1, 4'h9, 4'hD: pty = 1;
      4'h2, 4'hA, 4'hE: pty = 2;
      default:          pty = 3;
    endcase
    exp_pkt   = good ? pid_b[3:0] : 4'h0;
    st_err    = 1'b0;
    nst       = 0;
    flush_cyc = -1;
    occ       = 7'(bias);

    drive_bit(sync_b[0]);
    idle_cycle();
    @(negedge clk);
    check_eq("err_clr_on_sync", err, 0);
    check_eq("rdy_clr_on_sync", rdy, 0);
    for (int i = 1; i < 8; i++) drive_bit(sync_b[i]);
    for (int i = 0; i < 8; i++) drive_bit(pid_b[i]);
    if (good && pty == 0) flush_cyc = cyc + 1;
    idle_cycle();
    @(negedge clk);
    check_eq("active_after_pid", active, good && pty < 3);
    check_eq("pkt_after_pid", pkt, exp_pkt);

    for (int k = 0; k < body.size(); k++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 7) occ = 7'(bias + nst);
        drive_bit(body[k][i]);
      end
      if (good && pty == 0 && k >= 2 && !st_err) begin
        if (nst >= 64 || bias + nst >= 64) st_err = 1'b1;
        else begin
          pend.push_back('{cyc + 1, body[k-2]});
          nst++;
        end
      end
      if (abort_after == k + 1) begin
        idle_cycle();
        idle_cycle();
        #2 rst = 1'b1;
        #1;
        check_all_zero("abort");
        check_eq("abort_pending", pend.size(), 0);
        pend.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    for (int i = 0; i < tail; i++) drive_bit(1'($urandom));

    @(posedge clk); #1;
    shift_en = 1'($urandom);
    d_bit    = 1'($urandom);
    eop      = 1'b1;
    @(posedge clk); #1;
    eop      = 1'b0;
    shift_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    if (!good) exp_err = 1'b1;
    else begin
      case (pty)
        0:       exp_err = st_err || tail != 0 || nbody < 2;
        1:       exp_err = nbody != 2 || tail != 0;
        2:       exp_err = nbody != 0 || tail != 0;
        default: exp_err = 1'b1;
      endcase
    end
    check_eq("final_err", err, exp_err);
    check_eq("final_rdy", rdy, good && pty == 0 && !exp_err);
    check_eq("final_pkt", pkt, exp_pkt);
    check_eq("final_active", active, 0);
    check_eq("final_pending", pend.size(), 0);
    pend.delete();
  endtask

  logic [7:0] pids[8] = '{8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E, 8'hE1, 8'h69, 8'h2D};

  initial begin
    logic [7:0] p;
    int         nb, tl;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    idle_cycle();

    preset = '{8'h64, 8'h1D, 8'h57, 8'h76, 8'hAA, 8'hBB};
    send_pkt(8'h80, 8'hC3, 6, 0, 0, -1);
    send_pkt(8'h80, 8'hD2, 0, 0, 0, -1);
    send_pkt(8'h80, 8'hC4, 3, 0, 0, -1);
    send_pkt(8'h80, 8'h5A, 0, 0, 0, -1);
    send_pkt(8'h80, 8'h4B, 66, 0, 0, -1);
    send_pkt(8'h80, 8'h4B, 67, 0, 0, -1);
    send_pkt(8'h80, 8'hC3, 10, 0, 60, -1);
    send_pkt(8'h80, 8'hC3, 5, 3, 0, -1);
    send_pkt(8'h80, 8'hC3, 6, 0, 0, 4);
    send_pkt(8'h80, 8'hC3, 7, 0, 0, -1);
    send_pkt(8'h80, 8'hE1, 2, 0, 0, -1);
    send_pkt(8'h80, 8'h2D, 3, 0, 0, -1);
    send_pkt(8'h80, 8'h1E, 1, 0, 0, -1);
    send_pkt(8'h81, 8'hC3, 4, 0, 0, -1);
    send_pkt(8'h80, 8'hC3, 1, 0, 0, -1);

    for (int n = 0; n < 25; n++) begin
      p = pids[$urandom_range(0, 7)];
      case (p[3:0])
        4'h3, 4'hB:       nb = $urandom_range(0, 8);
        4'h1, 4'h9, 4'hD: nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : 2;
        default:          nb = ($urandom_range(0, 3) == 0) ? 1 : 0;
      endcase
      tl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      send_pkt(8'h80, p, nb, tl, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
